// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants and region decode for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_ROM  = 2'd1,
        REG_MMIO = 2'd2
    } region_t;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_LSU   = 1'b1
    } req_id_t;

    localparam logic [15:0] RAM_BASE   = 16'h0000;
    localparam logic [15:0] RAM_LAST   = 16'h3FFF;
    localparam logic [15:0] MMIO_BASE  = 16'h4000;
    localparam logic [15:0] MMIO_LAST  = 16'h7FFF;
    localparam logic [15:0] ROM_BASE   = 16'h8000;
    localparam logic [15:0] DPORT_ADDR = 16'h4000;
    localparam logic [15:0] DONE_ADDR  = 16'h4001;

    function automatic region_t decode_region(input logic [15:0] addr);
        if (addr[15:14] == 2'b00)
            return REG_RAM;
        else if (addr[15])
            return REG_ROM;
        else
            return REG_MMIO;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - core request/response channels and system bus of the arbiter
interface mem_arbiter_if;
    logic        f_req_valid;
    logic        f_req_ready;
    logic [15:0] f_addr;
    logic        f_resp_valid;
    logic [7:0]  f_resp_data;

    logic        l_req_valid;
    logic        l_req_ready;
    logic        l_we;
    logic [15:0] l_addr;
    logic [7:0]  l_wdata;
    logic        l_resp_valid;
    logic [7:0]  l_resp_data;

    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_data_w;
    logic [7:0]  mem_data_r;

    modport slave (
        input  f_req_valid, f_addr, l_req_valid, l_we, l_addr, l_wdata, mem_data_r,
        output f_req_ready, f_resp_valid, f_resp_data,
        output l_req_ready, l_resp_valid, l_resp_data,
        output mem_addr, mem_we, mem_data_w
    );

    modport master (
        output f_req_valid, f_addr, l_req_valid, l_we, l_addr, l_wdata, mem_data_r,
        input  f_req_ready, f_resp_valid, f_resp_data,
        input  l_req_ready, l_resp_valid, l_resp_data,
        input  mem_addr, mem_we, mem_data_w
    );
endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - two-way grant; round-robin when MEM_ARB_RR_EN is defined
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  req_id_t last_grant,
`endif
    input  logic    f_valid,
    input  logic    l_valid,
    output logic    f_grant,
    output logic    l_grant
);

    always_comb begin
        f_grant = 1'b0;
        l_grant = 1'b0;
`ifdef MEM_ARB_RR_EN
        // On contention, the requester not served last goes next.
        if (f_valid && l_valid) begin
            l_grant = (last_grant == REQ_FETCH);
            f_grant = (last_grant == REQ_LSU);
        end else begin
            l_grant = l_valid;
            f_grant = f_valid;
        end
`else
        l_grant = l_valid;
        f_grant = f_valid && !l_valid;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/LSU memory bus arbiter with MMIO page (option MEM_ARB_RR_EN)
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output logic [7:0]    dport_out,
    output logic          dport_write,
    output logic          done
);

    logic        f_grant, l_grant, gnt_any, gnt_we, mmio_wr;
    logic [15:0] gnt_addr, addr_q;
    region_t     gnt_region;

    logic        resp_valid_q, resp_pass_q;
    req_id_t     resp_owner_q;
    logic        f_hit, l_hit;

`ifdef MEM_ARB_RR_EN
    req_id_t last_grant_q;

    always_ff @(posedge clk) begin
        if (rst)
            last_grant_q <= REQ_FETCH;
        else if (gnt_any)
            last_grant_q <= l_grant ? REQ_LSU : REQ_FETCH;
    end
`endif

    // Valids are masked during reset so no grant can occur.
    mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .last_grant (last_grant_q),
`endif
        .f_valid    (bus.f_req_valid && !rst),
        .l_valid    (bus.l_req_valid && !rst),
        .f_grant    (f_grant),
        .l_grant    (l_grant)
    );

    assign bus.f_req_ready = f_grant;
    assign bus.l_req_ready = l_grant;

    assign gnt_any    = f_grant || l_grant;
    assign gnt_addr   = l_grant ? bus.l_addr : bus.f_addr;
    assign gnt_we     = l_grant && bus.l_we;
    assign gnt_region = decode_region(gnt_addr);
    assign mmio_wr    = gnt_we && (gnt_region == REG_MMIO);

    assign bus.mem_addr   = gnt_any ? gnt_addr : addr_q;
    assign bus.mem_we     = gnt_we && (gnt_region == REG_RAM);
    assign bus.mem_data_w = gnt_we ? bus.l_wdata : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= 16'h0000;
            resp_valid_q <= 1'b0;
            resp_owner_q <= REQ_FETCH;
            resp_pass_q  <= 1'b0;
            dport_out    <= 8'h00;
            dport_write  <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (gnt_any)
                addr_q <= gnt_addr;
            resp_valid_q <= gnt_any;
            resp_owner_q <= l_grant ? REQ_LSU : REQ_FETCH;
            resp_pass_q  <= gnt_any && !gnt_we && (gnt_region != REG_MMIO);
            dport_write  <= mmio_wr && (gnt_addr == DPORT_ADDR);
            if (mmio_wr && (gnt_addr == DPORT_ADDR))
                dport_out <= bus.l_wdata;
            if (mmio_wr && (gnt_addr == DONE_ADDR))
                done <= 1'b1;
        end
    end

    // A reset arriving while a response is due kills it in that same cycle.
    assign f_hit = resp_valid_q && !rst && (resp_owner_q == REQ_FETCH);
    assign l_hit = resp_valid_q && !rst && (resp_owner_q == REQ_LSU);

    assign bus.f_resp_valid = f_hit;
    assign bus.l_resp_valid = l_hit;
    assign bus.f_resp_data  = (f_hit && resp_pass_q) ? bus.mem_data_r : 8'h00;
    assign bus.l_resp_data  = (l_hit && resp_pass_q) ? bus.mem_data_r : 8'h00;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dport_out;
    logic       dport_write;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [0:16383];
    logic [7:0] rom [0:32767];

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dport_out   (dport_out),
        .dport_write (dport_write),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Synchronous system memory; the MMIO hole reads back junk the arbiter must hide.
    always @(posedge clk) begin
        if (bus.mem_we && !bus.mem_addr[15] && !bus.mem_addr[14])
            ram[bus.mem_addr[13:0]] <= bus.mem_data_w;
        if (bus.mem_addr[15])
            bus.mem_data_r <= rom[bus.mem_addr[14:0]];
        else if (!bus.mem_addr[14])
            bus.mem_data_r <= ram[bus.mem_addr[13:0]];
        else
            bus.mem_data_r <= 8'hEE;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.f_req_valid = 1'b0;
        bus.f_addr      = 16'h0000;
        bus.l_req_valid = 1'b0;
        bus.l_we        = 1'b0;
        bus.l_addr      = 16'h0000;
        bus.l_wdata     = 8'h00;
    endtask

    task automatic lsu_req(input logic we, input logic [15:0] addr, input logic [7:0] wdata);
        bus.l_req_valid = 1'b1;
        bus.l_we        = we;
        bus.l_addr      = addr;
        bus.l_wdata     = wdata;
    endtask

    logic [2:0] exp_lsu_win;

    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = 8'h00;
        for (int i = 0; i < 32768; i++) rom[i] = 8'h00;
        rom[15'h7FFC] = 8'hA9;
        rom[15'h0000] = 8'h11;
        ram[14'h0010] = 8'h22;
        bus.mem_data_r = 8'h00;
`ifdef MEM_ARB_RR_EN
        exp_lsu_win = 3'b101;
`else
        exp_lsu_win = 3'b111;
`endif

        // Reset values
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        check_eq("rst_f_ready",      bus.f_req_ready,  1'b0);
        check_eq("rst_l_ready",      bus.l_req_ready,  1'b0);
        check_eq("rst_f_resp_valid", bus.f_resp_valid, 1'b0);
        check_eq("rst_l_resp_valid", bus.l_resp_valid, 1'b0);
        check_eq("rst_f_resp_data",  bus.f_resp_data,  8'h00);
        check_eq("rst_l_resp_data",  bus.l_resp_data,  8'h00);
        check_eq("rst_mem_we",       bus.mem_we,       1'b0);
        check_eq("rst_mem_addr",     bus.mem_addr,     16'h0000);
        check_eq("rst_dport_write",  dport_write,      1'b0);
        check_eq("rst_dport_out",    dport_out,        8'h00);
        check_eq("rst_done",         done,             1'b0);
        bus.f_req_valid = 1'b1;
        bus.l_req_valid = 1'b1;
        #1;
        check_eq("rst_f_ready_valid", bus.f_req_ready, 1'b0);
        check_eq("rst_l_ready_valid", bus.l_req_ready, 1'b0);
        tick();
        idle_inputs();
        rst = 1'b0;

        // Lone fetch from ROM
        bus.f_req_valid = 1'b1;
        bus.f_addr      = 16'hFFFC;
        #1;
        check_eq("t1_f_ready",  bus.f_req_ready, 1'b1);
        check_eq("t1_l_ready",  bus.l_req_ready, 1'b0);
        check_eq("t1_mem_addr", bus.mem_addr,    16'hFFFC);
        tick();
        idle_inputs();
        check_eq("t1_f_resp_valid", bus.f_resp_valid, 1'b1);
        check_eq("t1_f_resp_data",  bus.f_resp_data,  8'hA9);
        check_eq("t1_l_resp_valid", bus.l_resp_valid, 1'b0);

        // Contention for three cycles
        for (int i = 0; i < 3; i++) begin
            bus.f_req_valid = 1'b1;
            bus.f_addr      = 16'h8000;
            lsu_req(1'b0, 16'h0010, 8'h00);
            #1;
            check_eq($sformatf("t2_l_ready_%0d", i), bus.l_req_ready, exp_lsu_win[2-i]);
            check_eq($sformatf("t2_f_ready_%0d", i), bus.f_req_ready, !exp_lsu_win[2-i]);
            tick();
            check_eq($sformatf("t2_l_resp_valid_%0d", i), bus.l_resp_valid, exp_lsu_win[2-i]);
            check_eq($sformatf("t2_f_resp_valid_%0d", i), bus.f_resp_valid, !exp_lsu_win[2-i]);
            check_eq($sformatf("t2_l_resp_data_%0d", i), bus.l_resp_data,
                     exp_lsu_win[2-i] ? 8'h22 : 8'h00);
            check_eq($sformatf("t2_f_resp_data_%0d", i), bus.f_resp_data,
                     exp_lsu_win[2-i] ? 8'h00 : 8'h11);
        end
        idle_inputs();

        // RAM write then read-back
        lsu_req(1'b1, 16'h0020, 8'h55);
        #1;
        check_eq("t3_wr_mem_we",   bus.mem_we,     1'b1);
        check_eq("t3_wr_data_w",   bus.mem_data_w, 8'h55);
        tick();
        check_eq("t3_wr_ack_valid", bus.l_resp_valid, 1'b1);
        check_eq("t3_wr_ack_data",  bus.l_resp_data,  8'h00);
        lsu_req(1'b0, 16'h0020, 8'h00);
        #1;
        check_eq("t3_rd_mem_we", bus.mem_we, 1'b0);
        tick();
        idle_inputs();
        check_eq("t3_rd_valid", bus.l_resp_valid, 1'b1);
        check_eq("t3_rd_data",  bus.l_resp_data,  8'h55);

        // MMIO data port and done flag
        lsu_req(1'b1, 16'h4000, 8'h3C);
        #1;
        check_eq("t4_dport_mem_we", bus.mem_we, 1'b0);
        tick();
        check_eq("t4_dport_write", dport_write, 1'b1);
        check_eq("t4_dport_out",   dport_out,   8'h3C);
        check_eq("t4_dport_ack",   bus.l_resp_valid, 1'b1);
        lsu_req(1'b1, 16'h4001, 8'h01);
        tick();
        idle_inputs();
        check_eq("t4_dport_pulse_end", dport_write, 1'b0);
        check_eq("t4_done_set",        done,        1'b1);
        repeat (10) tick();
        check_eq("t4_done_held",     done,         1'b1);
        check_eq("t4_dport_held",    dport_out,    8'h3C);
        check_eq("t4_mem_addr_idle", bus.mem_addr, 16'h4001);

        // ROM write and MMIO read
        lsu_req(1'b1, 16'h9000, 8'hAA);
        #1;
        check_eq("t5_rom_wr_mem_we", bus.mem_we, 1'b0);
        tick();
        check_eq("t5_rom_wr_ack",  bus.l_resp_valid, 1'b1);
        check_eq("t5_rom_wr_data", bus.l_resp_data,  8'h00);
        lsu_req(1'b0, 16'h5000, 8'h00);
        #1;
        check_eq("t5_mmio_rd_mem_we", bus.mem_we, 1'b0);
        tick();
        idle_inputs();
        check_eq("t5_mmio_rd_valid", bus.l_resp_valid, 1'b1);
        check_eq("t5_mmio_rd_data",  bus.l_resp_data,  8'h00);
        check_eq("t5_dport_kept",    dport_out,        8'h3C);

        // Reset during an in-flight read
        lsu_req(1'b0, 16'h0020, 8'h00);
        #1;
        check_eq("t6_l_ready", bus.l_req_ready, 1'b1);
        tick();
        idle_inputs();
        rst = 1'b1;
        #1;
        check_eq("t6_resp_suppressed", bus.l_resp_valid, 1'b0);
        check_eq("t6_resp_data_zero",  bus.l_resp_data,  8'h00);
        tick();
        check_eq("t6_done_cleared", done,            1'b0);
        check_eq("t6_dport_out",    dport_out,       8'h00);
        check_eq("t6_dport_write",  dport_write,     1'b0);
        check_eq("t6_mem_addr",     bus.mem_addr,    16'h0000);
        check_eq("t6_l_ready_rst",  bus.l_req_ready, 1'b0);
        rst = 1'b0;
        tick();
        check_eq("t6_no_late_l_resp", bus.l_resp_valid, 1'b0);
        check_eq("t6_no_late_f_resp", bus.f_resp_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
